vga_axil_regs: RTL

//  AXI-Lite slave register block for the VGA controller; terminates the vga_axil_if bus from the host/bench.

---
 rtl/vga_axil_pkg.sv | 42 ++++
 rtl/vga_axil_regs.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_axil_pkg.sv
// Shared AXI-Lite types and register map for the VGA controller register block.
package vga_axil_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;

    typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
    typedef logic [AXIL_DATA_W-1:0] axil_data_t;
    typedef logic [1:0]             axil_resp_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    localparam axil_addr_t CTRL_OFFS      = 32'h0000_0000;
    localparam axil_addr_t BG_COLOR_OFFS  = 32'h0000_0004;
    localparam axil_addr_t FRAME_CNT_OFFS = 32'h0000_0008;
    localparam axil_addr_t ID_OFFS        = 32'h0000_000C;

    // Word slots as seen by the decoder (byte lane bits are ignored).
    localparam logic [1:0] CTRL_SLOT      = CTRL_OFFS[3:2];
    localparam logic [1:0] BG_COLOR_SLOT  = BG_COLOR_OFFS[3:2];
    localparam logic [1:0] FRAME_CNT_SLOT = FRAME_CNT_OFFS[3:2];
    localparam logic [1:0] ID_SLOT        = ID_OFFS[3:2];

    typedef struct packed {
        logic test_pat;
        logic vga_en;
    } ctrl_reg_t;

    function automatic logic addr_mapped(input axil_addr_t addr);
        return addr[AXIL_ADDR_W-1:4] == '0;
    endfunction

    function automatic logic [1:0] addr_slot(input axil_addr_t addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/vga_axil_regs.sv
// AXI-Lite register block for the VGA controller: CTRL, BG_COLOR, FRAME_CNT and ID registers.
// Address ready rises together with the response valid, so each transfer closes in a single handshake.
module vga_axil_regs
    import vga_axil_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h5647_4101,
    parameter int          COLOR_W  = 12
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [31:0]        axil_araddr,
    input  logic               axil_arvalid,
    output logic               axil_arready,
    output logic [31:0]        axil_rdata,
    output logic [1:0]         axil_rresp,
    output logic               axil_rvalid,
    input  logic               axil_rready,
    input  logic [31:0]        axil_awaddr,
    input  logic               axil_awvalid,
    output logic               axil_awready,
    input  logic [31:0]        axil_wdata,
    input  logic [3:0]         axil_wstrb,
    input  logic               axil_wvalid,
    output logic               axil_wready,
    output logic [1:0]         axil_bresp,
    output logic               axil_bvalid,
    input  logic               axil_bready,
    input  logic               frame_done_i,
    output logic               vga_en_o,
    output logic               test_pat_o,
    output logic [COLOR_W-1:0] bg_color_o
);

    typedef enum logic { R_IDLE, R_RESP } rd_state_e;
    typedef enum logic { W_IDLE, W_RESP } wr_state_e;

    rd_state_e          rd_state;
    wr_state_e          wr_state;
    ctrl_reg_t          ctrl;
    logic [COLOR_W-1:0] bg_color;
    axil_data_t         frame_cnt;

    axil_data_t         rd_word;
    axil_resp_t         rd_resp;
    logic [1:0]         wr_slot;
    logic               wr_ok;
    logic               unused_bits;

    // Read data is captured from the live registers on the cycle the address is accepted.
    always_comb begin
        rd_word = '0;
        rd_resp = OKAY;
        if (!addr_mapped(axil_araddr)) begin
            rd_resp = SLVERR;
        end else begin
            case (addr_slot(axil_araddr))
                CTRL_SLOT:      rd_word[1:0] = ctrl;
                BG_COLOR_SLOT:  rd_word[COLOR_W-1:0] = bg_color;
                FRAME_CNT_SLOT: rd_word = frame_cnt;
                default:        rd_word = ID_VALUE;
            endcase
        end
    end

    assign wr_slot = addr_slot(axil_awaddr);
    assign wr_ok   = addr_mapped(axil_awaddr) && (wr_slot == CTRL_SLOT || wr_slot == BG_COLOR_SLOT);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_state     <= R_IDLE;
            axil_arready <= 1'b0;
            axil_rvalid  <= 1'b0;
            axil_rdata   <= '0;
            axil_rresp   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (axil_arvalid) begin
                        rd_state     <= R_RESP;
                        axil_arready <= 1'b1;
                        axil_rvalid  <= 1'b1;
                        axil_rdata   <= rd_word;
                        axil_rresp   <= rd_resp;
                    end
                end
                R_RESP: begin
                    if (axil_rready) begin
                        rd_state     <= R_IDLE;
                        axil_arready <= 1'b0;
                        axil_rvalid  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Registers commit only on the accept edge, so a held response never writes twice.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state     <= W_IDLE;
            axil_awready <= 1'b0;
            axil_wready  <= 1'b0;
            axil_bvalid  <= 1'b0;
            axil_bresp   <= '0;
            ctrl         <= '0;
            bg_color     <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (axil_awvalid && axil_wvalid) begin
                        wr_state     <= W_RESP;
                        axil_awready <= 1'b1;
                        axil_wready  <= 1'b1;
                        axil_bvalid  <= 1'b1;
                        axil_bresp   <= wr_ok ? OKAY : SLVERR;
                        if (wr_ok && wr_slot == CTRL_SLOT) begin
                            ctrl <= ctrl_reg_t'(axil_wdata[1:0]);
                        end
                        if (wr_ok && wr_slot == BG_COLOR_SLOT) begin
                            bg_color <= axil_wdata[COLOR_W-1:0];
                        end
                    end
                end
                W_RESP: begin
                    if (axil_bready) begin
                        wr_state     <= W_IDLE;
                        axil_awready <= 1'b0;
                        axil_wready  <= 1'b0;
                        axil_bvalid  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frame_cnt <= '0;
        end else if (frame_done_i) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end

    assign vga_en_o   = ctrl.vga_en;
    assign test_pat_o = ctrl.test_pat;
    assign bg_color_o = bg_color;

    // Partial-word writes are not supported; byte strobes must be all ones.
    a_wstrb_full: assert property (@(posedge clk) disable iff (!arst_n)
        axil_wvalid |-> (axil_wstrb == 4'hF));

    assign unused_bits = ^{axil_wstrb, axil_wdata[31:COLOR_W]};

endmodule
